// File: rtl/operand_forward_unit_if.sv
// Bundles the ID/EX forwarding-unit signals; master = pipeline side, slave = forwarding unit.
// advance acts as the pipeline-wide enable; there is no per-signal handshake.
interface operand_forward_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                      advance;
    logic                      issue_valid;
    logic [4:0]                issue_rd;
    logic                      issue_we;
    logic                      issue_is_load;
    logic [NUM_SRC*5-1:0]      src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic [DEPTH*XLEN-1:0]     stage_result;
    logic [NUM_SRC*XLEN-1:0]   rf_data;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
    logic [NUM_SRC*XLEN-1:0]   fwd_data;
    logic                      stall;

    modport master (
        output advance, issue_valid, issue_rd, issue_we, issue_is_load,
        output src_addr, src_used, stage_result, rf_data,
        input  fwd_sel, fwd_data, stall
    );

    modport slave (
        input  advance, issue_valid, issue_rd, issue_we, issue_is_load,
        input  src_addr, src_used, stage_result, rf_data,
        output fwd_sel, fwd_data, stall
    );
endinterface

// File: rtl/operand_forward_unit.sv
// Operand forwarding + load-use hazard unit; optional perf counters under FWD_PERF_CNT_EN.
// Latency: operand select/stall combinational from src_addr; tracking shift register updates 1 cycle after advance.
// Backpressure: advance=0 freezes tracking; stall holds IF/ID and turns the issuing instruction into a bubble.
module operand_forward_unit #(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_forward_unit_if.slave fwd
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_fwd_cnt
`endif
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } entry_t;

    entry_t [DEPTH-1:0]        entry_q;
    entry_t                    issue_entry;
    logic [NUM_SRC-1:0]        hazard;
    logic [NUM_SRC*SEL_W-1:0]  sel;
    logic [NUM_SRC*XLEN-1:0]   data;
    logic                      stall;
    logic                      found;
    logic [4:0]                addr;

    // Per source: scan stages youngest-first; the first match decides, older producers are shadowed.
    always_comb begin
        hazard = '0;
        sel    = '0;
        data   = fwd.rf_data;
        found  = 1'b0;
        addr   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            found = 1'b0;
            addr  = fwd.src_addr[i*5 +: 5];
            for (int j = 0; j < DEPTH; j++) begin
                if (!found && fwd.src_used[i] && (addr != 5'd0) && entry_q[j].valid &&
                    entry_q[j].we && (entry_q[j].rd == addr)) begin
                    found = 1'b1;
                    if (entry_q[j].is_load && (j < LOAD_STAGE)) begin
                        hazard[i] = 1'b1;
                    end else begin
                        sel[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
                        data[i*XLEN +: XLEN]  = fwd.stage_result[j*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    assign stall        = |hazard;
    assign fwd.stall    = stall;
    assign fwd.fwd_sel  = sel;
    assign fwd.fwd_data = data;

    always_comb begin
        issue_entry         = '0;
        issue_entry.valid   = fwd.issue_valid && !stall;
        issue_entry.rd      = fwd.issue_rd;
        issue_entry.we      = fwd.issue_we;
        issue_entry.is_load = fwd.issue_is_load;
        if (!issue_entry.valid) begin
            issue_entry = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (fwd.advance) begin
            for (int j = 1; j < DEPTH; j++) begin
                entry_q[j] <= entry_q[j-1];
            end
            entry_q[0] <= issue_entry;
        end
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] fwd_hits;

    always_comb begin
        fwd_hits = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel[i*SEL_W +: SEL_W] != '0) begin
                fwd_hits = fwd_hits + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else if (fwd.advance) begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            perf_fwd_cnt <= perf_fwd_cnt + fwd_hits;
        end
    end
`endif
endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed scenarios then random traffic against an issue-history model.
`timescale 1ns/1ps
module tb_operand_forward_unit;
    localparam int XLEN       = 32;
    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 1;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    operand_forward_unit_if #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus();

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
    operand_forward_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
        .clk(clk), .rst_n(rst_n), .fwd(bus),
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt));
`else
    operand_forward_unit #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) dut (
        .clk(clk), .rst_n(rst_n), .fwd(bus));
`endif

    int total = 0;
    int bad   = 0;

    // Model: list of real instructions that entered the pipe, stamped with the advance count at entry.
    // An instruction's stage is the number of advances since it entered minus one.
    typedef struct {
        int         seq;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } instr_t;
    instr_t flight[$];
    int     adv_cnt = 0;

    int          exp_sel [NUM_SRC];
    logic [31:0] exp_data[NUM_SRC];
    logic        exp_stall;
    logic [31:0] exp_stall_cnt = 0;
    logic [31:0] exp_fwd_cnt   = 0;

    task automatic predict();
        exp_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            logic [4:0] a;
            int best_age;
            int best_k;
            a        = bus.src_addr[i*5 +: 5];
            best_age = DEPTH;
            best_k   = -1;
            exp_sel[i]  = 0;
            exp_data[i] = bus.rf_data[i*XLEN +: XLEN];
            if (bus.src_used[i] && a != 5'd0) begin
                foreach (flight[k]) begin
                    int age;
                    age = adv_cnt - 1 - flight[k].seq;
                    if (age >= 0 && age < DEPTH && flight[k].we && flight[k].rd == a && age < best_age) begin
                        best_age = age;
                        best_k   = k;
                    end
                end
            end
            if (best_k >= 0) begin
                if (flight[best_k].is_load && best_age < LOAD_STAGE) begin
                    exp_stall = 1'b1;
                end else begin
                    exp_sel[i]  = best_age + 1;
                    exp_data[i] = bus.stage_result[best_age*XLEN +: XLEN];
                end
            end
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        predict();
        expect_val({tag, ".stall"}, 32'(bus.stall), 32'(exp_stall));
        for (int i = 0; i < NUM_SRC; i++) begin
            expect_val($sformatf("%s.sel%0d", tag, i), 32'(bus.fwd_sel[i*SEL_W +: SEL_W]), 32'(exp_sel[i]));
            expect_val($sformatf("%s.data%0d", tag, i), bus.fwd_data[i*XLEN +: XLEN], exp_data[i]);
        end
`ifdef FWD_PERF_CNT_EN
        expect_val({tag, ".perf_stall"}, perf_stall_cnt, exp_stall_cnt);
        expect_val({tag, ".perf_fwd"}, perf_fwd_cnt, exp_fwd_cnt);
`endif
    endtask

    // Check current outputs, then clock once and advance the model with the pre-edge inputs.
    task automatic step(input string tag);
        instr_t t;
        #1;
        check_all(tag);
        predict();
        @(posedge clk);
        if (rst_n && bus.advance) begin
            exp_stall_cnt = exp_stall_cnt + 32'(exp_stall);
            for (int i = 0; i < NUM_SRC; i++)
                if (exp_sel[i] != 0) exp_fwd_cnt = exp_fwd_cnt + 32'd1;
            if (bus.issue_valid && !exp_stall) begin
                t.seq = adv_cnt; t.rd = bus.issue_rd; t.we = bus.issue_we; t.is_load = bus.issue_is_load;
                flight.push_back(t);
            end
            adv_cnt++;
            while (flight.size() > 0 && adv_cnt - 1 - flight[0].seq >= DEPTH) void'(flight.pop_front());
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        flight.delete();
        exp_stall_cnt = 0;
        exp_fwd_cnt   = 0;
        #1;
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd, input logic we, input logic ld);
        bus.issue_valid = v; bus.issue_rd = rd; bus.issue_we = we; bus.issue_is_load = ld;
    endtask

    task automatic set_src(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
        bus.src_addr = {a1, a0};
        bus.src_used = used;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.advance      = 1'b1;
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        set_src(5'd0, 5'd0, 2'b00);
        bus.stage_result = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus.rf_data      = {32'hAAAA_0001, 32'hAAAA_0000};
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset: three valid entries, then an async reset pulse mid-cycle.
        issue(1'b1, 5'd1, 1'b1, 1'b0); step("fill1");
        issue(1'b1, 5'd2, 1'b1, 1'b0); step("fill2");
        issue(1'b1, 5'd3, 1'b1, 1'b0); step("fill3");
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        set_src(5'd1, 5'd3, 2'b11);
        #1;
        expect_val("pre_rst.sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd3);
        expect_val("pre_rst.sel1", 32'(bus.fwd_sel[SEL_W +: SEL_W]), 32'd1);
        #(-0);
        do_reset("rst");
        expect_val("rst.stall", 32'(bus.stall), 32'd0);
        expect_val("rst.data0", bus.fwd_data[0 +: XLEN], 32'hAAAA_0000);
        step("post_rst");

        // ALU back-to-back forward from EX.
        issue(1'b1, 5'd5, 1'b1, 1'b0); step("alu_issue");
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        set_src(5'd5, 5'd0, 2'b01);
        bus.stage_result[0 +: XLEN] = 32'hDEAD_BEEF;
        #1;
        expect_val("alu.sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd1);
        expect_val("alu.data0", bus.fwd_data[0 +: XLEN], 32'hDEAD_BEEF);
        step("alu");

        // Youngest producer wins when rd=7 sits in stages 0 and 1.
        issue(1'b1, 5'd7, 1'b1, 1'b0); step("prio_a");
        issue(1'b1, 5'd7, 1'b1, 1'b0); step("prio_b");
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        set_src(5'd7, 5'd0, 2'b01);
        #1;
        expect_val("prio.sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd1);
        step("prio");

        // Load-use: one stall cycle, bubble behind the load, then forward from MEM.
        set_src(5'd0, 5'd0, 2'b00);
        issue(1'b1, 5'd3, 1'b1, 1'b1); step("ld_issue");
        issue(1'b1, 5'd9, 1'b1, 1'b0);
        set_src(5'd0, 5'd3, 2'b10);
        #1;
        expect_val("ldu.stall", 32'(bus.stall), 32'd1);
        expect_val("ldu.sel1", 32'(bus.fwd_sel[SEL_W +: SEL_W]), 32'd0);
        step("ldu");
        set_src(5'd9, 5'd3, 2'b11);
        #1;
        expect_val("ldu2.stall", 32'(bus.stall), 32'd0);
        expect_val("ldu2.sel1", 32'(bus.fwd_sel[SEL_W +: SEL_W]), 32'd2);
        expect_val("ldu2.bubble", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd0);
        step("ldu2");

        // x0 never forwards; unused sources never forward.
        issue(1'b1, 5'd0, 1'b1, 1'b1); step("x0_issue");
        issue(1'b1, 5'd4, 1'b1, 1'b0);
        set_src(5'd0, 5'd0, 2'b11);
        #1;
        expect_val("x0.sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd0);
        expect_val("x0.stall", 32'(bus.stall), 32'd0);
        step("x0");
        issue(1'b0, 5'd0, 1'b0, 1'b0);
        set_src(5'd4, 5'd4, 2'b00);
        #1;
        expect_val("unused.sel0", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd0);
        step("unused");

        // Hold: advance low for five cycles while issuing.
        bus.advance = 1'b0;
        issue(1'b1, 5'd8, 1'b1, 1'b0);
        set_src(5'd8, 5'd4, 2'b11);
        for (int c = 0; c < 5; c++) begin
            #1;
            expect_val("hold.sel1", 32'(bus.fwd_sel[SEL_W +: SEL_W]), 32'd2);
            step("hold");
        end
        bus.advance = 1'b1;

        // Random traffic with a small register range to provoke matches.
        for (int n = 0; n < 400; n++) begin
            bus.advance = ($urandom_range(0, 7) != 0);
            issue($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            set_src(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            bus.stage_result = {$urandom, $urandom, $urandom};
            bus.rf_data      = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
